// File: rtl/ov5640_cfg_seq.sv
// ----------------------------------------------------------------------------
// ov5640_cfg_seq
// Walks an external register table and writes each {reg_addr, reg_val} entry
// to the OV5640 through an SCCB write master. A table entry whose address is
// 16'hFFFF is not written. Instead it inserts a wait of reg_val milliseconds.
// A NACKed write is retried up to MAX_RETRY times before the sequencer parks
// in an error state.
//
// Ports
//   sysclk      : single clock, rising edge
//   rst         : asynchronous, active-high reset
//   pwr_done    : sensor powered and out of reset (level)
//   cfg_start   : one-cycle pulse, restart the table from entry 0
//   rom_addr    : table index presented to the external table
//   rom_data    : table word {reg_addr[15:0], reg_val[7:0]}, one cycle latency
//   sccb_req    : write request, held until sccb_done
//   sccb_addr   : register address for the current write
//   sccb_wdata  : register value for the current write
//   sccb_done   : one-cycle pulse, write transaction finished
//   sccb_nack   : qualified by sccb_done, slave did not acknowledge
//   cfg_busy    : sequencing in progress
//   cfg_done    : every table entry written
//   cfg_err     : retries exhausted on some entry
// ----------------------------------------------------------------------------
module ov5640_cfg_seq #(
   parameter int REG_NUM   = 252,
   parameter int CLK_FREQ  = 50_000_000,
   parameter int MAX_RETRY = 3
) (
   input  logic        sysclk,
   input  logic        rst,
   input  logic        pwr_done,
   input  logic        cfg_start,
   output logic [9:0]  rom_addr,
   input  logic [23:0] rom_data,
   output logic        sccb_req,
   output logic [15:0] sccb_addr,
   output logic [7:0]  sccb_wdata,
   input  logic        sccb_done,
   input  logic        sccb_nack,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err
);

   localparam int MS_CYC = CLK_FREQ / 1000;
   // A sub-kHz clock would give a zero-length millisecond. Use at least one
   // cycle per millisecond in that case.
   localparam int MS_EFF = (MS_CYC < 1) ? 1 : MS_CYC;
   localparam int DLY_W  = $clog2(255 * MS_EFF + 1);
   localparam int RTY_W  = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [9:0]       LAST_IDX = 10'(REG_NUM - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_LATCH    = 4'd2;
   localparam logic [3:0] S_WRITE    = 4'd3;
   localparam logic [3:0] S_WAIT_ACK = 4'd4;
   localparam logic [3:0] S_DELAY    = 4'd5;
   localparam logic [3:0] S_NEXT     = 4'd6;
   localparam logic [3:0] S_DONE     = 4'd7;
   localparam logic [3:0] S_ERR      = 4'd8;

   logic [3:0]       r_state;
   logic [9:0]       r_index;
   logic [RTY_W-1:0] r_retry;
   logic [DLY_W-1:0] r_dly_cnt;
   logic             r_sccb_req;
   logic [15:0]      r_sccb_addr;
   logic [7:0]       r_sccb_wdata;
   logic             r_restart_pend;

   logic [DLY_W-1:0] w_dly_prod;
   logic [DLY_W-1:0] w_dly_load;
   logic             w_bus_owned;

   assign w_dly_prod = DLY_W'(rom_data[7:0]) * DLY_W'(MS_EFF);
   // A zero-millisecond delay entry still costs exactly one cycle.
   assign w_dly_load = (rom_data[7:0] == 8'd0) ? DLY_W'(1) : w_dly_prod;

   // Once sccb_req is on the wire, the master owns the transaction. Restart
   // and power loss wait for sccb_done so that a half-finished write is never
   // abandoned.
   assign w_bus_owned = (r_state == S_WAIT_ACK) || ((r_state == S_WRITE) && r_sccb_req);

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_index        <= '0;
         r_retry        <= '0;
         r_dly_cnt      <= '0;
         r_sccb_req     <= 1'b0;
         r_sccb_addr    <= '0;
         r_sccb_wdata   <= '0;
         r_restart_pend <= 1'b0;
      end else if (w_bus_owned) begin
         if (cfg_start && pwr_done) begin
            r_restart_pend <= 1'b1;
         end
         if (r_state == S_WRITE) begin
            r_state <= S_WAIT_ACK;
         end else if (sccb_done) begin
            r_sccb_req     <= 1'b0;
            r_restart_pend <= 1'b0;
            if (!pwr_done) begin
               r_state   <= S_IDLE;
               r_index   <= '0;
               r_retry   <= '0;
               r_dly_cnt <= '0;
            end else if (r_restart_pend || cfg_start) begin
               r_state   <= S_FETCH;
               r_index   <= '0;
               r_retry   <= '0;
               r_dly_cnt <= '0;
            end else if (!sccb_nack) begin
               r_retry <= '0;
               r_state <= S_NEXT;
            end else if (r_retry < RTY_MAX) begin
               r_retry <= r_retry + 1'b1;
               r_state <= S_WRITE;
            end else begin
               r_state <= S_ERR;
            end
         end
      end else if (!pwr_done) begin
         r_state        <= S_IDLE;
         r_index        <= '0;
         r_retry        <= '0;
         r_dly_cnt      <= '0;
         r_sccb_req     <= 1'b0;
         r_restart_pend <= 1'b0;
      end else if (cfg_start) begin
         r_state        <= S_FETCH;
         r_index        <= '0;
         r_retry        <= '0;
         r_dly_cnt      <= '0;
         r_sccb_req     <= 1'b0;
         r_restart_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_index <= '0;
               r_retry <= '0;
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_sccb_addr  <= rom_data[23:8];
               r_sccb_wdata <= rom_data[7:0];
               if (rom_data[23:8] == 16'hFFFF) begin
                  r_dly_cnt <= w_dly_load;
                  r_state   <= S_DELAY;
               end else begin
                  r_sccb_req <= 1'b1;
                  r_state    <= S_WRITE;
               end
            end
            S_WRITE: begin
               // WRITE is only reached with sccb_req low on a retry. That
               // cycle is the mandatory low gap, and the request rises next.
               r_sccb_req <= 1'b1;
            end
            S_DELAY: begin
               if (r_dly_cnt <= DLY_W'(1)) begin
                  r_dly_cnt <= '0;
                  r_state   <= S_NEXT;
               end else begin
                  r_dly_cnt <= r_dly_cnt - 1'b1;
               end
            end
            S_NEXT: begin
               if (r_index == LAST_IDX) begin
                  r_state <= S_DONE;
               end else begin
                  r_index <= r_index + 10'd1;
                  r_state <= S_FETCH;
               end
            end
            S_DONE, S_ERR: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rom_addr   = r_index;
   assign sccb_req   = r_sccb_req;
   assign sccb_addr  = r_sccb_addr;
   assign sccb_wdata = r_sccb_wdata;
   assign cfg_busy   = (r_state == S_FETCH) || (r_state == S_LATCH) ||
                       (r_state == S_WRITE) || (r_state == S_WAIT_ACK) ||
                       (r_state == S_DELAY) || (r_state == S_NEXT);
   assign cfg_done   = (r_state == S_DONE);
   assign cfg_err    = (r_state == S_ERR);

endmodule
